// File: rtl/fetch_queue_pkg.sv
// Shared CPU constants and the fetch-queue entry layout.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH = 4;
  localparam int unsigned FQ_AW    = 2;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Entry layout: pc in [63:32], instruction in [31:0].
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side valid/ready handshakes of the fetch queue.
interface fetch_queue_if #(
  parameter int unsigned AW = fetch_queue_pkg::FQ_AW
) ();

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc_plus;
  logic [31:0]   out_instr;
  logic [AW:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_plus, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_pc_plus, out_instr, count
  );

endinterface

// File: rtl/fq_storage.sv
// Entry array: synchronous write port, asynchronous read port, cleared on reset.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned AW    = FQ_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  fq_entry_t       wdata,
  input  logic [AW-1:0]   raddr,
  output fq_entry_t       rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode with flush on redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  parameter int unsigned AW    = FQ_AW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  fetch_queue_if.slave   bus
);

  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  fq_entry_t     wdata;
  fq_entry_t     rdata;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // Flush forces both handshakes low, so nothing transfers in a flush cycle.
  assign bus.in_ready  = !full && !flush;
  assign bus.out_valid = !empty && !flush;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign wdata = '{pc: bus.in_pc, instr: bus.in_instr};

  fq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (tail_q),
    .wdata (wdata),
    .raddr (head_q),
    .rdata (rdata)
  );

  assign bus.out_pc      = rdata.pc;
  assign bus.out_instr   = rdata.instr;
  assign bus.out_pc_plus = rdata.pc + PC_STEP;
  assign bus.count       = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally at DEPTH since DEPTH == 2**AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized checks of fetch_queue against a queue-based model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH = FQ_DEPTH;

  logic clk;
  logic rst_n;
  logic flush;

  fetch_queue_if #(.AW(FQ_AW)) bus ();

  fetch_queue #(.DEPTH(FQ_DEPTH), .AW(FQ_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  fq_entry_t q[$];
  bit        accepted = 0;
  bit        m_push;
  bit        m_pop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = rdy;
    flush         = fl;
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  // Reference model: an ordered list of held entries, updated by the transfer rules.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      accepted = 0;
    end else if (flush) begin
      q.delete();
      accepted = 0;
    end else begin
      m_push = bus.in_valid && (q.size() < int'(DEPTH));
      m_pop  = bus.out_ready && (q.size() > 0);
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back('{pc: bus.in_pc, instr: bus.in_instr});
      accepted = m_push;
    end
  end

  // Compare outputs against the model midway through every cycle out of reset.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("count", 32'(bus.count), 32'(q.size()));
      check("in_ready", 32'(bus.in_ready), 32'((q.size() < int'(DEPTH)) && !flush));
      check("out_valid", 32'(bus.out_valid), 32'((q.size() > 0) && !flush));
      if (q.size() > 0 && !flush) begin
        check("out_pc", bus.out_pc, q[0].pc);
        check("out_instr", bus.out_instr, q[0].instr);
        check("out_pc_plus", bus.out_pc_plus, q[0].pc + 32'd4);
      end
    end
  end

  initial begin
    int vp;
    int rp;
    logic [31:0] pc;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0);

    // Reset then idle
    #12;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_pc", bus.out_pc, 32'h0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_out_pc_plus", bus.out_pc_plus, 32'h4);
    rst_n = 1'b1;

    // Single push then pop
    set_in(1, RESET_PC, 32'h3c01_0001, 0, 0);
    to_pos();
    set_in(0, 0, 0, 0, 0);
    to_neg();
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_pc", bus.out_pc, 32'h0000_3000);
    check("single_pc_plus", bus.out_pc_plus, 32'h0000_3004);
    check("single_instr", bus.out_instr, 32'h3c01_0001);
    check("single_count", 32'(bus.count), 32'd1);
    set_in(0, 0, 0, 1, 0);
    to_pos();
    set_in(0, 0, 0, 0, 0);
    to_neg();
    check("single_pop_count", 32'(bus.count), 32'd0);
    to_pos();

    // Fill with decode stalled; a fifth entry must be held off
    for (int i = 0; i < 4; i++) begin
      set_in(1, RESET_PC + 32'(4 * i), 32'h1000_0000 + 32'(i), 0, 0);
      to_pos();
    end
    set_in(1, 32'h0000_3010, 32'h1000_0004, 0, 0);
    to_neg();
    check("full_count", 32'(bus.count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    to_pos();
    to_neg();
    check("full_held_count", 32'(bus.count), 32'd4);
    to_pos();
    set_in(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      to_neg();
      check("drain_pc", bus.out_pc, 32'h0000_3000 + 32'(4 * i));
      to_pos();
    end
    set_in(0, 0, 0, 0, 0);
    to_neg();
    check("drain_empty", 32'(bus.count), 32'd0);
    to_pos();

    // Streaming across pointer wrap with one entry in flight
    set_in(1, 32'h0000_3100, 32'h2000_0000, 0, 0);
    to_pos();
    for (int i = 0; i < 10; i++) begin
      set_in(1, 32'h0000_3104 + 32'(4 * i), 32'h2000_0001 + 32'(i), 1, 0);
      to_neg();
      check("stream_count", 32'(bus.count), 32'd1);
      check("stream_pc", bus.out_pc, 32'h0000_3100 + 32'(4 * i));
      to_pos();
    end
    set_in(0, 0, 0, 1, 0);
    to_neg();
    check("stream_last_pc", bus.out_pc, 32'h0000_3128);
    to_pos();
    set_in(0, 0, 0, 0, 0);
    to_neg();
    check("stream_drained", 32'(bus.count), 32'd0);
    to_pos();

    // Flush with three entries while both sides are active
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h0000_3020 + 32'(4 * i), 32'h3000_0000 + 32'(i), 0, 0);
      to_pos();
    end
    set_in(1, 32'h0000_3030, 32'h3000_0003, 1, 1);
    to_neg();
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_pre_count", 32'(bus.count), 32'd3);
    to_pos();
    set_in(0, 0, 0, 0, 0);
    to_neg();
    check("flush_post_count", 32'(bus.count), 32'd0);
    check("flush_post_ready", 32'(bus.in_ready), 32'd1);
    set_in(1, 32'h0000_3040, 32'h3000_0040, 0, 0);
    to_pos();
    set_in(0, 0, 0, 0, 0);
    to_neg();
    check("flush_next_valid", 32'(bus.out_valid), 32'd1);
    check("flush_next_pc", bus.out_pc, 32'h0000_3040);
    set_in(0, 0, 0, 1, 0);
    to_pos();
    set_in(0, 0, 0, 0, 0);

    // Asynchronous reset between edges with two entries held
    set_in(1, 32'h0000_3050, 32'h4000_0000, 0, 0);
    to_pos();
    set_in(1, 32'h0000_3054, 32'h4000_0001, 0, 0);
    to_pos();
    set_in(1, 32'h0000_3058, 32'h4000_0002, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_out_pc", bus.out_pc, 32'h0);
    set_in(0, 0, 0, 0, 0);
    to_neg();
    #2;
    rst_n = 1'b1;
    set_in(1, 32'h0000_3060, 32'h4000_0010, 0, 0);
    to_pos();
    set_in(0, 0, 0, 0, 0);
    to_neg();
    check("arst_resume_valid", 32'(bus.out_valid), 32'd1);
    check("arst_resume_pc", bus.out_pc, 32'h0000_3060);
    check("arst_resume_count", 32'(bus.count), 32'd1);
    to_pos();

    // Randomized traffic with shifting producer/consumer rates
    vp = 50;
    rp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        vp = int'($urandom_range(95, 10));
        rp = int'($urandom_range(95, 10));
      end
      if (!(bus.in_valid && !accepted)) begin
        pc = $urandom;
        pc[1:0] = 2'b00;
        if ($urandom_range(7) == 0) pc = 32'hFFFF_FFFC;
        bus.in_valid = (int'($urandom_range(99)) < vp);
        bus.in_pc    = pc;
        bus.in_instr = $urandom;
      end
      bus.out_ready = (int'($urandom_range(99)) < rp);
      flush         = ($urandom_range(24) == 0);
      to_pos();
    end
    set_in(0, 0, 0, 0, 0);
    to_pos();
    to_pos();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
